// File: rtl/i2s_dac_serializer.sv
// i2s_dac_serializer: slave-mode stereo serializer driving dacdat from codec-supplied bclk/daclrc
//   sys_clk      system clock, the only clock (f_sys >= 8*f_bclk)
//   reset        asynchronous reset, active-high
//   bclk         codec bit clock, asynchronous, synchronised internally
//   daclrc       codec LR clock, asynchronous, synchronised internally
//   dacdat       serial data to the codec, updated one cycle after each synced bclk fall
//   s_left       left sample of the offered frame
//   s_right      right sample of the offered frame
//   s_valid      offered frame is valid
//   s_ready      holding register empty
//   mute         sampled at frame load; a muted frame is sent as zeros
//   underrun     one-cycle pulse when a frame load finds the holding register empty
//   frame_start  one-cycle pulse at every left-slot load
module i2s_dac_serializer #(
    parameter int   SAMPLE_W    = 24,
    parameter int   MODE        = 0,
    parameter logic LEFT_LVL    = 1'b0,
    parameter int   SYNC_STAGES = 2
) (
    input  logic                sys_clk,
    input  logic                reset,
    input  logic                bclk,
    input  logic                daclrc,
    output logic                dacdat,
    input  logic [SAMPLE_W-1:0] s_left,
    input  logic [SAMPLE_W-1:0] s_right,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic                mute,
    output logic                underrun,
    output logic                frame_start
);
    localparam int CW = $clog2(SAMPLE_W + 1);
    localparam logic [CW-1:0] DONE = CW'(SAMPLE_W);

    logic [SYNC_STAGES-1:0] bclk_sync, lrc_sync;
    logic                   bclk_q, lrc_seen, prev_lrc, hold_full;
    logic [SAMPLE_W-1:0]    hold_l, hold_r, sh_r, sh_cur, slot_data;
    logic [CW-1:0]          bit_cnt;
    logic                   bclk_s, lrc_s, fall, slot_start, load, accept;

    assign bclk_s  = bclk_sync[SYNC_STAGES-1];
    assign lrc_s   = lrc_sync[SYNC_STAGES-1];
    assign s_ready = ~hold_full;

    always_comb begin
        fall       = bclk_q & ~bclk_s;
        slot_start = fall & lrc_seen & (lrc_s != prev_lrc);
        load       = slot_start & (lrc_s == LEFT_LVL);
        accept     = s_valid & ~hold_full;
        // left slot takes the frame being loaded now; right slot takes the R half latched at that load
        slot_data  = load ? ((hold_full & ~mute) ? hold_l : '0) : sh_r;
    end

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            bclk_sync   <= '0;
            lrc_sync    <= '0;
            bclk_q      <= 1'b0;
            lrc_seen    <= 1'b0;
            prev_lrc    <= 1'b0;
            hold_full   <= 1'b0;
            hold_l      <= '0;
            hold_r      <= '0;
            sh_r        <= '0;
            sh_cur      <= '0;
            bit_cnt     <= DONE;
            dacdat      <= 1'b0;
            underrun    <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            bclk_sync   <= {bclk_sync[SYNC_STAGES-2:0], bclk};
            lrc_sync    <= {lrc_sync[SYNC_STAGES-2:0], daclrc};
            bclk_q      <= bclk_s;
            // an accept only happens while empty, so it never collides with a consuming load
            hold_full   <= accept | (hold_full & ~load);
            underrun    <= load & ~hold_full;
            frame_start <= load;
            if (accept) begin
                hold_l <= s_left;
                hold_r <= s_right;
            end
            if (fall & ~lrc_seen) begin
                lrc_seen <= 1'b1;
                prev_lrc <= lrc_s;
            end
            if (load)
                sh_r <= (hold_full & ~mute) ? hold_r : '0;
            if (slot_start) begin
                prev_lrc <= lrc_s;
                dacdat   <= (MODE == 1) & slot_data[SAMPLE_W-1];
                sh_cur   <= (MODE == 1) ? slot_data << 1 : slot_data;
                bit_cnt  <= (MODE == 1) ? CW'(1) : '0;
            end else if (fall & lrc_seen) begin
                dacdat  <= (bit_cnt != DONE) & sh_cur[SAMPLE_W-1];
                sh_cur  <= sh_cur << 1;
                bit_cnt <= (bit_cnt != DONE) ? bit_cnt + CW'(1) : DONE;
            end
        end
    end
endmodule

// File: tb/tb_i2s_dac_serializer.sv
// tb_i2s_dac_serializer: random-stimulus bench for both framing modes against a frame-level model
module tb_i2s_dac_serializer;
    localparam int SW = 24;

    logic          sys_clk, reset, bclk, daclrc, s_valid, mute;
    logic [SW-1:0] s_left, s_right;
    logic          dacdat0, s_ready0, underrun0, frame_start0;
    logic          dacdat1, s_ready1, underrun1, frame_start1;

    i2s_dac_serializer #(.SAMPLE_W(SW), .MODE(0), .LEFT_LVL(1'b0), .SYNC_STAGES(2)) dut0 (
        .sys_clk(sys_clk), .reset(reset), .bclk(bclk), .daclrc(daclrc), .dacdat(dacdat0),
        .s_left(s_left), .s_right(s_right), .s_valid(s_valid), .s_ready(s_ready0),
        .mute(mute), .underrun(underrun0), .frame_start(frame_start0));

    i2s_dac_serializer #(.SAMPLE_W(SW), .MODE(1), .LEFT_LVL(1'b0), .SYNC_STAGES(2)) dut1 (
        .sys_clk(sys_clk), .reset(reset), .bclk(bclk), .daclrc(daclrc), .dacdat(dacdat1),
        .s_left(s_left), .s_right(s_right), .s_valid(s_valid), .s_ready(s_ready1),
        .mute(mute), .underrun(underrun1), .frame_start(frame_start1));

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
        end
    endtask

    // frame-level model: one-deep holding register, current L/R frame, slot position
    int            cyc = 0;
    int            load_at = -1;
    int            pmode = 0;
    logic          m_full = 1'b0;
    logic [SW-1:0] m_l, m_r;
    logic [SW-1:0] cur_l = '0;
    logic [SW-1:0] cur_r = '0;
    logic          exp_ur = 1'b0;
    logic          exp_fs = 1'b0;
    logic          seen = 1'b0;
    logic          active = 1'b0;
    logic          prev = 1'b0;
    logic          slot_left = 1'b0;
    int            k = 0;
    logic [2*SW-1:0] fixed_q[$];

    function automatic logic exp_bit(input int mode, input logic [SW-1:0] d, input int kk);
        int idx;
        idx = (mode == 1) ? kk : kk - 1;
        return (idx >= 0 && idx < SW) ? d[SW-1-idx] : 1'b0;
    endfunction

    task automatic tick();
        logic acc;
        @(posedge sys_clk);
        cyc++;
        acc    = 1'b0;
        exp_fs = 1'b0;
        exp_ur = 1'b0;
        if (reset) begin
            m_full = 1'b0;
            cur_l  = '0;
            cur_r  = '0;
        end else begin
            acc    = s_valid && !m_full;
            exp_fs = (cyc == load_at);
            exp_ur = exp_fs && !m_full;
            if (exp_fs) begin
                cur_l  = (m_full && !mute) ? m_l : '0;
                cur_r  = (m_full && !mute) ? m_r : '0;
                m_full = 1'b0;
            end
            if (acc) begin
                m_full = 1'b1;
                m_l    = s_left;
                m_r    = s_right;
            end
        end
        #1;
        if (!reset) begin
            chk("ready0", 32'(s_ready0), 32'(!m_full));
            chk("ready1", 32'(s_ready1), 32'(!m_full));
            chk("underrun0", 32'(underrun0), 32'(exp_ur));
            chk("underrun1", 32'(underrun1), 32'(exp_ur));
            chk("frame_start0", 32'(frame_start0), 32'(exp_fs));
            chk("frame_start1", 32'(frame_start1), 32'(exp_fs));
        end
        if (acc) s_valid = 1'b0;
        if (!s_valid && ((pmode == 3 && fixed_q.size() > 0) || pmode == 1 ||
                         (pmode == 2 && $urandom_range(0, 3) == 0))) begin
            if (fixed_q.size() > 0) {s_left, s_right} = fixed_q.pop_front();
            else begin
                s_left  = SW'($urandom);
                s_right = SW'($urandom);
            end
            s_valid = 1'b1;
        end
    endtask

    task automatic model_fall(input logic lrc);
        if (!seen) begin
            seen = 1'b1;
            prev = lrc;
        end else if (lrc != prev) begin
            prev      = lrc;
            active    = 1'b1;
            k         = 0;
            slot_left = (lrc == 1'b0);
            if (slot_left) load_at = cyc + 3;
        end else k++;
    endtask

    // one bclk period: fall (with daclrc change) then rise 8 sys_clk later, where the codec samples
    task automatic bit_period(input logic lrc);
        logic [SW-1:0] d;
        tick();
        bclk   = 1'b0;
        daclrc = lrc;
        model_fall(lrc);
        repeat (8) tick();
        d = slot_left ? cur_l : cur_r;
        chk("dacdat_i2s", 32'(dacdat0), 32'(active ? exp_bit(0, d, k) : 1'b0));
        chk("dacdat_lj", 32'(dacdat1), 32'(active ? exp_bit(1, d, k) : 1'b0));
        bclk = 1'b1;
        repeat (7) tick();
    endtask

    task automatic frame(input int nl, input int nr);
        repeat (nl) bit_period(1'b0);
        repeat (nr) bit_period(1'b1);
    endtask

    task automatic do_reset();
        tick();
        reset = 1'b1;
        #1;
        chk("rst_dacdat0", 32'(dacdat0), 32'(0));
        chk("rst_dacdat1", 32'(dacdat1), 32'(0));
        chk("rst_ready", 32'(s_ready0), 32'(1));
        seen    = 1'b0;
        active  = 1'b0;
        load_at = -1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset   = 1'b1;
        bclk    = 1'b1;
        daclrc  = 1'b1;
        s_valid = 1'b0;
        s_left  = '0;
        s_right = '0;
        mute    = 1'b0;
        #1;
        chk("init_dacdat", 32'(dacdat0 | dacdat1), 32'(0));
        chk("init_ready", 32'(s_ready0 & s_ready1), 32'(1));
        chk("init_underrun", 32'(underrun0 | underrun1), 32'(0));
        chk("init_frame_start", 32'(frame_start0 | frame_start1), 32'(0));
        fixed_q.push_back({24'h800001, 24'h7FFFFE});
        pmode = 3;
        repeat (2) tick();
        reset = 1'b0;
        repeat (4) bit_period(1'b1);
        frame(32, 32);
        pmode = 0;
        frame(32, 32);
        pmode = 1;
        repeat (4) frame(32, 32);
        pmode = 2;
        repeat (6) begin
            mute = ($urandom_range(0, 3) == 0);
            frame($urandom_range(16, 34), $urandom_range(16, 34));
        end
        mute  = 1'b0;
        pmode = 1;
        frame(32, 32);
        repeat (10) bit_period(1'b0);
        do_reset();
        repeat (22) bit_period(1'b0);
        repeat (32) bit_period(1'b1);
        frame(32, 32);
        frame(32, 32);
        frame(16, 16);
        frame(32, 16);
        mute = 1'b1;
        frame(32, 32);
        mute = 1'b0;
        frame(32, 32);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
